// File: rtl/cube_frame_scheduler.sv
// Frame scheduler for an 8x8x8 cube: captures frames from the selected source,
// presents them only at scan-refresh boundaries, and inserts a blank frame on every source switch.
module cube_frame_scheduler #(
  parameter  int N_SRC        = 4,
  parameter  int DWELL_FRAMES = 64,
  localparam int SW           = $clog2(N_SRC),
  localparam int DW           = $clog2(DWELL_FRAMES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC*512-1:0] src_frame_flat,
  input  logic [N_SRC-1:0]     src_valid,
  output logic [N_SRC-1:0]     src_run,
  input  logic                 next_req,
  input  logic                 auto_mode,
  input  logic                 freeze,
  input  logic                 scan_done,
  output logic [511:0]         frame_out,
  output logic                 swap_pulse,
  output logic [SW-1:0]        cur_src,
  output logic [7:0]           drop_cnt
);

  typedef enum logic {RUN, SWITCH} state_t;

  state_t          r_state;
  logic            r_pend;
  logic [511:0]    r_pend_buf;
  logic [DW-1:0]   r_dwell;

  logic [511:0]    w_sel_frame;
  logic            w_cap, w_swap, w_dwell_hit, w_trig;
  logic [SW-1:0]   w_next_src;

  assign w_sel_frame = src_frame_flat[int'(cur_src)*512 +: 512];
  assign w_cap       = src_valid[cur_src] & ~freeze;
  assign w_swap      = scan_done & r_pend;
  // only the swap that reaches the limit triggers; a saturated count never re-triggers
  assign w_dwell_hit = (r_dwell == DW'(DWELL_FRAMES - 1));
  assign w_trig      = next_req | (auto_mode & ~freeze & w_swap & w_dwell_hit);
  assign w_next_src  = (cur_src == SW'(N_SRC - 1)) ? '0 : cur_src + SW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_pend     <= 1'b0;
      r_pend_buf <= '0;
      r_dwell    <= '0;
      frame_out  <= '0;
      swap_pulse <= 1'b0;
      cur_src    <= '0;
      src_run    <= N_SRC'(1);
      drop_cnt   <= '0;
    end else begin
      swap_pulse <= 1'b0;
      case (r_state)
        RUN: begin
          // frame_out always takes the old buffer, even when a capture lands this cycle
          if (w_swap) begin
            frame_out  <= r_pend_buf;
            swap_pulse <= 1'b1;
          end
          if (w_cap && r_pend && !w_swap && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
          if (w_trig) begin
            r_state    <= SWITCH;
            src_run    <= '0;
            r_pend     <= 1'b0;
            r_pend_buf <= '0;
            r_dwell    <= '0;
          end else begin
            if (w_cap) begin
              r_pend_buf <= w_sel_frame;
              r_pend     <= 1'b1;
            end else if (w_swap) begin
              r_pend     <= 1'b0;
            end
            if (w_swap && !freeze && r_dwell != DW'(DWELL_FRAMES))
              r_dwell <= r_dwell + DW'(1);
          end
        end
        SWITCH: begin
          if (scan_done) begin
            frame_out  <= '0;
            swap_pulse <= 1'b1;
            cur_src    <= w_next_src;
            src_run    <= N_SRC'(1) << w_next_src;
            r_state    <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_frame_scheduler.sv
// Directed + randomized bench for cube_frame_scheduler against a rule-level reference model.
module tb_cube_frame_scheduler;
  localparam int N  = 4;
  localparam int DF = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*512-1:0] src_frame_flat;
  logic [N-1:0]     src_valid, src_run;
  logic             next_req, auto_mode, freeze, scan_done, swap_pulse;
  logic [511:0]     frame_out;
  logic [1:0]       cur_src;
  logic [7:0]       drop_cnt;

  int vectors = 0, miscompares = 0;

  cube_frame_scheduler #(.N_SRC(N), .DWELL_FRAMES(DF)) dut (
    .clk(clk), .rst(rst), .src_frame_flat(src_frame_flat), .src_valid(src_valid),
    .src_run(src_run), .next_req(next_req), .auto_mode(auto_mode), .freeze(freeze),
    .scan_done(scan_done), .frame_out(frame_out), .swap_pulse(swap_pulse),
    .cur_src(cur_src), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  // reference state: "blanking" means a switch is waiting for the next refresh boundary
  bit           m_blanking;
  int           m_src, m_dwell, m_drop;
  bit           m_has_pend, m_pulse;
  logic [511:0] m_pend, m_out;

  function automatic logic [511:0] frame_of(input int k);
    return src_frame_flat[k*512 +: 512];
  endfunction

  task automatic model_reset();
    m_blanking = 0; m_src = 0; m_dwell = 0; m_drop = 0;
    m_has_pend = 0; m_pulse = 0; m_pend = '0; m_out = '0;
  endtask

  task automatic model_step();
    bit take, show, leave;
    if (rst) begin model_reset(); return; end
    m_pulse = 0;
    if (m_blanking) begin
      if (scan_done) begin
        m_out = '0; m_pulse = 1; m_src = (m_src + 1) % N; m_blanking = 0;
      end
      return;
    end
    take  = src_valid[m_src] && !freeze;
    show  = scan_done && m_has_pend;
    leave = next_req || (auto_mode && !freeze && show && m_dwell + 1 == DF);
    if (show) begin m_out = m_pend; m_pulse = 1; end
    if (take && m_has_pend && !show) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    if (leave) begin
      m_blanking = 1; m_has_pend = 0; m_pend = '0; m_dwell = 0;
    end else begin
      if (show) m_has_pend = 0;
      if (take) begin m_pend = frame_of(m_src); m_has_pend = 1; end
      if (show && !freeze && m_dwell < DF) m_dwell++;
    end
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp_v[63:0]);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] run_exp;
    run_exp = m_blanking ? '0 : N'(1) << m_src;
    chk("frame_out",  frame_out,  m_out);
    chk("swap_pulse", 512'(swap_pulse), 512'(m_pulse));
    chk("cur_src",    512'(cur_src),    512'(m_src));
    chk("src_run",    512'(src_run),    512'(run_exp));
    chk("drop_cnt",   512'(drop_cnt),   512'(m_drop));
  endtask

  task automatic tick(input logic [N-1:0] v, input logic sd, input logic nr);
    src_valid = v; scan_done = sd; next_req = nr;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic rand_frame(input int k);
    for (int w = 0; w < 16; w++) src_frame_flat[k*512 + w*32 +: 32] = $urandom;
  endtask

  logic [511:0] fb;
  int sw_hits;

  initial begin
    src_frame_flat = '0; src_valid = '0; next_req = 0; auto_mode = 0;
    freeze = 0; scan_done = 0; rst = 1;
    model_reset();
    tick('0, 0, 0); tick('0, 0, 0);
    rst = 0;

    // T1: idle with periodic refresh
    for (int i = 0; i < 32; i++) tick('0, (i % 8) == 7, 0);
    chk("t1_idle_frame", frame_out, 512'd0);
    chk("t1_idle_run", 512'(src_run), 512'(4'b0001));

    // T2: one frame, row0 = FF
    src_frame_flat[7:0] = 8'hFF;
    tick(4'b0001, 0, 0); tick('0, 0, 0); tick('0, 0, 0); tick('0, 1, 0);
    chk("t2_row0", 512'(frame_out[7:0]), 512'(8'hFF));
    chk("t2_pulse", 512'(swap_pulse), 512'd1);
    tick('0, 0, 0);

    // T3: overwrite, saturation, same-cycle capture + swap
    rand_frame(0); tick(4'b0001, 0, 0);
    rand_frame(0); fb = frame_of(0); tick(4'b0001, 0, 0);
    tick('0, 1, 0);
    chk("t3_shows_B", frame_out, fb);
    chk("t3_drop1", 512'(drop_cnt), 512'd1);
    for (int i = 0; i < 301; i++) begin rand_frame(0); tick(4'b0001, 0, 0); end
    chk("t3_drop_sat", 512'(drop_cnt), 512'd255);
    fb = frame_of(0);
    rand_frame(0); tick(4'b0001, 1, 0);
    chk("t3_same_cycle", frame_out, fb);
    fb = frame_of(0);
    tick('0, 1, 0);
    chk("t3_C_pending", frame_out, fb);

    // T4: manual advance and wrap
    tick('0, 0, 1);
    chk("t4_run_off", 512'(src_run), 512'd0);
    tick('0, 0, 0); tick('0, 1, 0);
    chk("t4_blank", frame_out, 512'd0);
    chk("t4_cur1", 512'(cur_src), 512'd1);
    chk("t4_run1", 512'(src_run), 512'(4'b0010));
    for (int s = 0; s < 3; s++) begin tick('0, 0, 1); tick('0, 1, 0); end
    chk("t4_wrap", 512'(cur_src), 512'd0);

    // T5: auto-dwell advance, then freeze holds everything
    auto_mode = 1;
    for (int i = 0; i < DF; i++) begin rand_frame(0); tick(4'b0001, 0, 0); tick('0, 1, 0); end
    chk("t5_run_off", 512'(src_run), 512'd0);
    tick('0, 1, 0);
    chk("t5_cur1", 512'(cur_src), 512'd1);
    freeze = 1;
    for (int i = 0; i < 3 * DF; i++) begin rand_frame(1); tick(4'b0010, 0, 0); tick('0, 1, 0); end
    chk("t5_frozen_src", 512'(cur_src), 512'd1);
    freeze = 0; auto_mode = 0;

    // T6: reset mid-switch with a pending frame
    rand_frame(1); tick(4'b0010, 0, 0);
    tick('0, 0, 1);
    rst = 1; tick('0, 0, 0); rst = 0;
    chk("t6_reset_run", 512'(src_run), 512'(4'b0001));
    chk("t6_reset_drop", 512'(drop_cnt), 512'd0);
    tick(4'b0010, 0, 0); tick('0, 1, 0);
    chk("t6_ignored", 512'(swap_pulse), 512'd0);

    // randomized phase
    sw_hits = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rand_frame($urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      if ($urandom_range(0, 63) == 0) auto_mode = ~auto_mode;
      rst = ($urandom_range(0, 499) == 0);
      tick(N'($urandom) & N'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0);
      if (m_blanking) sw_hits++;
    end
    rst = 0;
    chk("rand_switch_seen", 512'(sw_hits > 0), 512'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
